// File: rtl/out_ser_tri_pkg.sv
// Shared definitions for the out_ser_tri serializer: FSM state encoding and bit-order selectors.
package out_ser_tri_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } order_e;

endpackage

// File: rtl/out_ser_tri.sv
// Parallel-to-serial pad driver: shifts words out on OQ, drives TQ low only while bits are on the
// wire, and inserts a high-Z turnaround gap between bursts.
//
// state    | meaning
// ST_IDLE  | pad released, waiting for a word
// ST_SHIFT | driving bits; reload on the last bit keeps the burst going
// ST_TURN  | pad released, counting down the turnaround gap
module out_ser_tri
    import out_ser_tri_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int TURN      = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             OQ,
    output logic             TQ,
    output logic             BUSY
);

    localparam int     CW    = $clog2(WIDTH);
    localparam int     TW    = $clog2(TURN) + 1;
    localparam order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB : ORDER_LSB;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg, sreg_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [TW-1:0]    tcnt, tcnt_nx;
    logic             tq_q, tq_nx;
    logic             ready;
    logic             xfer;

    // Zero fill means the register is empty once a word has fully left, so OQ idles low for free.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (ORDER == ORDER_MSB)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {1'b0, v[WIDTH-1:1]};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            tcnt  <= '0;
            tq_q  <= 1'b1;
        end else begin
            state <= state_nx;
            sreg  <= sreg_nx;
            cnt   <= cnt_nx;
            tcnt  <= tcnt_nx;
            tq_q  <= tq_nx;
        end
    end

    always_comb begin
        ready    = (state == ST_IDLE) || ((state == ST_SHIFT) && (cnt == '0));
        DREADY   = ready && !RST;
        xfer     = DVALID && DREADY;
        state_nx = state;
        sreg_nx  = sreg;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        tq_nx    = tq_q;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    state_nx = ST_SHIFT;
                    sreg_nx  = D;
                    cnt_nx   = CW'(WIDTH - 1);
                    tq_nx    = 1'b0;
                end
            end
            ST_SHIFT: begin
                sreg_nx = shift_once(sreg);
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (xfer) begin
                    sreg_nx = D;
                    cnt_nx  = CW'(WIDTH - 1);
                end else begin
                    state_nx = ST_TURN;
                    tcnt_nx  = TW'(TURN - 1);
                    tq_nx    = 1'b1;
                end
            end
            ST_TURN: begin
                if (tcnt == '0)
                    state_nx = ST_IDLE;
                else
                    tcnt_nx = tcnt - 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                tq_nx    = 1'b1;
            end
        endcase
    end

    assign OQ   = (ORDER == ORDER_MSB) ? sreg[WIDTH-1] : sreg[0];
    assign TQ   = tq_q;
    assign BUSY = (state != ST_IDLE);

endmodule

// File: tb/tb_out_ser_tri.sv
// Bench for out_ser_tri: two instances (TURN=2 MSB-first, TURN=3 LSB-first) share stimulus and are
// checked every cycle against a wire-bit queue model, plus literal checks of the test-plan scenarios.
module tb_out_ser_tri;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d;
    logic         dvalid;
    logic [1:0]   dready, oq, tq, busy;

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 1'b0;

    // Model: per instance, the bits still to appear on the wire (head at bit 0) and the gap left.
    logic [31:0] mbits [2];
    int          mcnt  [2];
    int          mgap  [2];

    always #5 clk = ~clk;

    out_ser_tri #(.WIDTH(W), .TURN(2), .MSB_FIRST(1)) dut_a (
        .CLK(clk), .RST(rst), .D(d), .DVALID(dvalid),
        .DREADY(dready[0]), .OQ(oq[0]), .TQ(tq[0]), .BUSY(busy[0])
    );

    out_ser_tri #(.WIDTH(W), .TURN(3), .MSB_FIRST(0)) dut_b (
        .CLK(clk), .RST(rst), .D(d), .DVALID(dvalid),
        .DREADY(dready[1]), .OQ(oq[1]), .TQ(tq[1]), .BUSY(busy[1])
    );

    function automatic int turn_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic logic m_ready(input int i);
        return !rst && ((mcnt[i] == 1) || (mcnt[i] == 0 && mgap[i] == 0));
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic xf;
            xf = dvalid && m_ready(i);
            if (rst) begin
                mcnt[i]  = 0;
                mgap[i]  = 0;
                mbits[i] = '0;
            end else begin
                if (mcnt[i] > 0) begin
                    mbits[i] = mbits[i] >> 1;
                    mcnt[i]--;
                    if (mcnt[i] == 0 && !xf) mgap[i] = turn_of(i);
                end else if (mgap[i] > 0) begin
                    mgap[i]--;
                end
                if (xf) begin
                    for (int b = 0; b < W; b++)
                        mbits[i][mcnt[i] + b] = (i == 0) ? d[W-1-b] : d[b];
                    mcnt[i] += W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dready[%0d]", i), dready[i], m_ready(i));
                check($sformatf("oq[%0d]", i), oq[i], (mcnt[i] > 0) ? mbits[i][0] : 1'b0);
                check($sformatf("tq[%0d]", i), tq[i], mcnt[i] == 0);
                check($sformatf("busy[%0d]", i), busy[i], (mcnt[i] > 0) || (mgap[i] > 0));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        dvalid = 1'b0;
        while (!(dready === 2'b11 && busy === 2'b00) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0]  a5;
        logic [15:0] stream;
        a5     = 8'hA5;
        stream = 16'hFF00;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mgap[i] = 0; mbits[i] = '0;
        end
        rst = 1'b1; dvalid = 1'b0; d = '0;
        tick();
        armed = 1'b1;
        check("reset_tq", tq[0], 1'b1);
        check("reset_oq", oq[0], 1'b0);
        check("reset_busy", busy[1], 1'b0);
        check("reset_dready", dready[0], 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("post_reset_dready", dready[0], 1'b1);

        // single word, MSB first on instance a
        d = a5; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        check("single_first_lsb_b", oq[1], a5[0]);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check($sformatf("single_bit%0d", i), oq[0], a5[7-i]);
            check($sformatf("single_tq%0d", i), tq[0], 1'b0);
        end
        tick();
        check("single_tq_release", tq[0], 1'b1);
        tick();
        check("single_gap_dready", dready[0], 1'b0);
        tick();
        check("single_dready_back", dready[0], 1'b1);
        wait_idle();

        // back-to-back FF then 00
        d = 8'hFF; dvalid = 1'b1;
        tick();
        d = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            if (k == 8) dvalid = 1'b0;
            check($sformatf("b2b_oq%0d", k), oq[0], stream[15-k]);
            check($sformatf("b2b_tq%0d", k), tq[0], 1'b0);
            check($sformatf("b2b_dready%0d", k), dready[0], (k == 7) || (k == 15));
        end
        wait_idle();

        // LSB first on instance b
        d = 8'h01; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check($sformatf("lsb_bit%0d", i), oq[1], i == 0);
        end
        wait_idle();

        // reset mid-burst
        d = a5; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_dready_a", dready[0], 1'b0);
        check("rst_dready_b", dready[1], 1'b0);
        tick();
        check("rst_tq", tq[0], 1'b1);
        check("rst_oq", oq[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        rst = 1'b0;
        #1;
        check("rst_release_dready", dready[0], 1'b1);
        wait_idle();

        // turnaround with pending data on instance b (TURN=3), D toggling throughout
        d = 8'h3C; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            d = W'($urandom);
            tick();
        end
        dvalid = 1'b1;
        for (int k = 8; k <= 11; k++) begin
            if (k > 8) tick();
            d = W'($urandom);
            #1;
            check($sformatf("turn_tq%0d", k), tq[1], 1'b1);
            check($sformatf("turn_dready%0d", k), dready[1], k == 11);
        end
        tick();
        check("turn_restart_tq", tq[1], 1'b0);
        dvalid = 1'b0;
        wait_idle();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            dvalid = ($urandom_range(0, 3) != 0);
            d      = W'($urandom);
            tick();
        end
        rst = 1'b0; dvalid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_ser_tri.md
# out_ser_tri

Parallel-to-serial output stage with tri-state control that feeds a tri-state output buffer pad. It takes words from the core fabric over a valid/ready handshake and shifts them out one bit per clock on `OQ`. It drives the enable `TQ` so that the pad is driven only while bits are on the wire. A programmable high-Z turnaround gap separates bursts, so a shared single-wire line can be handed back to other drivers.

## Interface
- `WIDTH`, 8: bits per word, ≥ 2.
- `TURN`, 2: high-Z cycles after a burst before a new word is accepted, ≥ 1.
- `MSB_FIRST`, 1: 1 = bit `WIDTH-1` shifted first; 0 = bit 0 first.

Ports:
- `CLK`  in  1  the only clock; all logic acts on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `D`  in  WIDTH  word to transmit.
- `DVALID`  in  1  `D` is valid.
- `DREADY`  out  1  block accepts `D` this cycle; a transfer occurs when `DVALID` and `DREADY` are both high at a rising edge.
- `OQ`  out  1  serial data to the buffer data input.
- `TQ`  out  1  to the buffer tri-state input; 1 = pad high-Z, 0 = pad driven.
- `BUSY`  out  1  high in SHIFT and TURN.

## Operation
- States: IDLE, SHIFT, TURN. Encoding is 2 bits.
- **IDLE**
  - Outputs: `TQ`=1, `OQ`=0, `DREADY`=1.
  - On a transfer: load the shift register with `D`, load the bit counter with `WIDTH-1`, and go to SHIFT.
- **SHIFT**
  - Outputs: `TQ`=0. `OQ` = current head bit of the shift register.
  - Each cycle the register shifts one bit and the counter decrements.
  - `DREADY` = 1 only while the counter is 0, i.e. on the last bit of a word.
- **Last bit of a word (counter = 0)**
  - If a transfer occurs: reload the register and the counter, stay in SHIFT. `TQ` stays 0 with no gap, so the burst continues.
  - Otherwise: go to TURN and load the turnaround counter with `TURN-1`.
- **TURN**
  - Outputs: `TQ`=1, `OQ`=0, `DREADY`=0.
  - The turnaround counter decrements each cycle; at 0, go to IDLE.
- `OQ` and `TQ` come straight from flops, with no combinational path from inputs. `DREADY` and `BUSY` decode the state and counters only, with no dependency on `DVALID`.
- `D` is ignored whenever `DREADY`=0.
- Counters are `$clog2(WIDTH)` and `$clog2(TURN)+1` bits wide. They never wrap: each is reloaded before it can underflow.

## Timing
- **Reset**
  - `RST` high at an edge puts the block in IDLE after that edge, with `OQ`=0, `TQ`=1, `BUSY`=0.
  - `DREADY` is forced to 0 in any cycle in which `RST` is high.
- **Reset mid-burst:** the frame is aborted. `TQ` is 1 from the edge after `RST` is sampled, and no TURN gap is inserted.
- **Latency:** a word accepted at edge k has its first bit on `OQ` with `TQ`=0 from edge k+1. Its last bit is held from edge k+WIDTH to edge k+WIDTH+1.
- **Throughput:** back-to-back words give an uninterrupted stream of one bit per cycle.
- **Gap between bursts:** the earliest acceptance after a burst ends at edge j is at edge j+TURN, so `TQ`=1 for at least TURN+1 cycles.
- **`DVALID` dropped:** if `DVALID` deasserts on the last bit, the burst ends; a late `DVALID` is not recovered.
- **Tri-state timing:** `TQ` deasserts on the same edge as the first `OQ` bit and reasserts on the edge after the last bit, so the pad never drives stale data.

## Structure
- Shared package `out_ser_tri_pkg` holds:
  - the state encoding constants `ST_IDLE`=0, `ST_SHIFT`=1, `ST_TURN`=2;
  - the bit-order constants.
- Single module with no sub-module. The shift register, the two counters and the FSM are all local.

## Test plan
- **Single word:** reset, then `WIDTH`=8, `MSB_FIRST`=1, `D`=8'hA5 accepted at edge 0.
  - `OQ` = 1,0,1,0,0,1,0,1 during edges 1–8 with `TQ`=0.
  - `TQ`=1 from edge 9.
  - `DREADY`=1 again at edge 11 (TURN=2).
- **Back-to-back:** 8'hFF then 8'h00 with `DVALID` held high.
  - 16 consecutive driven bits, `TQ`=0 throughout.
  - `DREADY` pulses only at bit 7 of each word.
- **LSB-first:** `MSB_FIRST`=0, `D`=8'h01 → first `OQ` bit is 1, the remaining seven are 0.
- **Reset mid-burst:** assert `RST` at bit 3 of 8'hA5.
  - Next cycle: `TQ`=1, `OQ`=0, `BUSY`=0.
  - `DREADY` = 0 while `RST` is high, then 1.
- **Turnaround with pending data:** `DVALID` held high from the end of a burst with TURN=3.
  - No acceptance for 3 cycles.
  - `TQ`=1 for 4 cycles, then the new word starts.
- **Ignored input:** toggle `D` during SHIFT and TURN → no effect on `OQ`.
